// File: rtl/sram_mem_arbiter_pkg.sv
// Shared types and lane helpers for the two-client SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  localparam int NUM_CLIENTS = 2;

  function automatic logic [3:0] lane_byte_en(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(size_e sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Right-shift amount that brings the addressed lane down to bit 0.
  function automatic logic [4:0] lane_shift(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return {off, 3'b000};
      SZ_HALF: return {off[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sram_mem_arbiter_lane_align.sv
// Read-side lane extraction: SRAM word + byte offset + size -> right-aligned, zero-extended data.
module sram_lane_align
  import sram_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  output logic [31:0] data_o
);

  size_e       sz;
  logic [31:0] shifted;

  always_comb begin
    sz      = size_e'(size_i);
    shifted = word_i >> lane_shift(sz, off_i);
    case (sz)
      SZ_BYTE: data_o = {24'd0, shifted[7:0]};
      SZ_HALF: data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Two-client round-robin arbiter and lane aligner in front of a byte-enabled single-port SRAM.
// Optional SRAM_ARB_MISALIGN_ERR_EN: misaligned/reserved-size requests are flagged instead of issued.
module sram_mem_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int WA    = $clog2(DEPTH),
  localparam int AW    = WA + 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CLIENTS-1:0]          req_valid_i,
  output logic [NUM_CLIENTS-1:0]          req_ready_o,
  input  logic [NUM_CLIENTS-1:0]          req_we_i,
  input  logic [NUM_CLIENTS-1:0][1:0]     req_size_i,
  input  logic [NUM_CLIENTS-1:0][AW-1:0]  req_addr_i,
  input  logic [NUM_CLIENTS-1:0][31:0]    req_wdata_i,
  output logic [NUM_CLIENTS-1:0]          resp_valid_o,
  input  logic [NUM_CLIENTS-1:0]          resp_ready_i,
  output logic [NUM_CLIENTS-1:0][31:0]    resp_rdata_o,
  output logic [NUM_CLIENTS-1:0]          resp_err_o,
  output logic                            sram_wr_en_o,
  output logic                            sram_rd_en_o,
  output logic [WA-1:0]                   sram_address_o,
  output logic [31:0]                     sram_data_in_o,
  output logic [3:0]                      sram_byte_en_o,
  input  logic [31:0]                     sram_data_out_i
);

  logic                               ptr_q;
  logic                               infl_q;
  logic                               infl_cl_q;
  logic [1:0]                         infl_off_q;
  logic [1:0]                         infl_sz_q;
  logic                               infl_err_q;
  logic [NUM_CLIENTS-1:0]             resp_valid_q;
  logic [NUM_CLIENTS-1:0]             resp_err_q;
  logic [NUM_CLIENTS-1:0][31:0]       resp_rdata_q;

  logic [NUM_CLIENTS-1:0] elig;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   gsel;
  logic                   gany;
  logic [AW-1:0]          gaddr;
  size_e                  gsz;
  logic                   mis;
  logic                   issue;
  logic [31:0]            rd_aligned;

  assign gsel  = grant[1];
  assign gany  = |grant;
  assign gaddr = req_addr_i[gsel];
  assign gsz   = size_e'(req_size_i[gsel]);

`ifdef SRAM_ARB_MISALIGN_ERR_EN
  assign mis = is_misaligned(gsz, gaddr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign issue = gany & ~mis;

  // A client stays blocked from the moment its read is accepted until the response is consumed.
  always_comb begin
    elig[0] = req_valid_i[0] & ~rst_i & ~resp_valid_q[0] & ~(infl_q & ~infl_cl_q);
    elig[1] = req_valid_i[1] & ~rst_i & ~resp_valid_q[1] & ~(infl_q & infl_cl_q);
    grant   = '0;
    if (&elig) grant[ptr_q] = 1'b1;
    else       grant = elig;
  end

  always_comb begin
    sram_wr_en_o   = issue & req_we_i[gsel];
    sram_rd_en_o   = issue & ~req_we_i[gsel];
    sram_address_o = issue ? gaddr[AW-1:2] : '0;
    sram_data_in_o = issue ? lane_replicate(gsz, req_wdata_i[gsel]) : '0;
    sram_byte_en_o = issue ? lane_byte_en(gsz, gaddr[1:0]) : '0;
  end

  sram_lane_align u_align (
    .word_i (sram_data_out_i),
    .off_i  (infl_off_q),
    .size_i (infl_sz_q),
    .data_o (rd_aligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= 1'b0;
      infl_q       <= 1'b0;
      infl_cl_q    <= 1'b0;
      infl_off_q   <= '0;
      infl_sz_q    <= '0;
      infl_err_q   <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_rdata_q <= '0;
    end else begin
      if (gany) ptr_q <= ~gsel;
      infl_q     <= gany & ~req_we_i[gsel];
      infl_cl_q  <= gsel;
      infl_off_q <= gaddr[1:0];
      infl_sz_q  <= gsz;
      infl_err_q <= mis;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        if (resp_valid_q[c] && resp_ready_i[c]) resp_valid_q[c] <= 1'b0;
      end
      if (infl_q) begin
        resp_valid_q[infl_cl_q] <= 1'b1;
        resp_rdata_q[infl_cl_q] <= infl_err_q ? 32'd0 : rd_aligned;
        resp_err_q[infl_cl_q]   <= infl_err_q;
      end
    end
  end

  assign req_ready_o  = grant;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench for sram_mem_arbiter: directed table, corner sequences and random traffic
// checked against a byte-addressed memory / per-client response model.
module tb_sram_mem_arbiter;

  localparam int DEPTH = 1024;
  localparam int WA    = 10;
  localparam int AW    = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid, req_ready, req_we;
  logic [1:0][1:0]      req_size;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][31:0]     req_wdata;
  logic [1:0]           resp_valid, resp_ready, resp_err;
  logic [1:0][31:0]     resp_rdata;
  logic                 sram_wr_en, sram_rd_en;
  logic [WA-1:0]        sram_address;
  logic [31:0]          sram_data_in;
  logic [3:0]           sram_byte_en;
  logic [31:0]          sram_data_out;

  always #5 clk = ~clk;

  sram_mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err),
    .sram_wr_en_o(sram_wr_en), .sram_rd_en_o(sram_rd_en), .sram_address_o(sram_address),
    .sram_data_in_o(sram_data_in), .sram_byte_en_o(sram_byte_en), .sram_data_out_i(sram_data_out)
  );

  // SRAM behavioural model: byte-enabled write, registered read.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (sram_wr_en)
      for (int b = 0; b < 4; b++)
        if (sram_byte_en[b]) mem[sram_address][8*b +: 8] <= sram_data_in[8*b +: 8];
    if (sram_rd_en) sram_data_out <= mem[sram_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flat byte memory plus per-client "read outstanding" bookkeeping.
  logic [7:0]  rmem [0:255];
  bit          pend [2];
  int          age  [2];
  logic [31:0] exp_d [2];
  bit          exp_e [2];
  int          mptr;

  function automatic bit misal(int a, int sz);
`ifdef SRAM_ARB_MISALIGN_ERR_EN
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(int a, int sz);
    int base = a - (a % 4);
    int off  = (a % 4 >= 2) ? 2 : 0;
    if (sz == 0) return {24'd0, rmem[a]};
    if (sz == 1) return {16'd0, rmem[base+off+1], rmem[base+off]};
    return {rmem[base+3], rmem[base+2], rmem[base+1], rmem[base]};
  endfunction

  task automatic ref_write(int a, int sz, logic [31:0] wd);
    int base = a - (a % 4);
    int off  = (a % 4 >= 2) ? 2 : 0;
    if (sz == 0) rmem[a] = wd[7:0];
    else if (sz == 1) begin
      rmem[base+off] = wd[7:0]; rmem[base+off+1] = wd[15:8];
    end else begin
      rmem[base] = wd[7:0]; rmem[base+1] = wd[15:8]; rmem[base+2] = wd[23:16]; rmem[base+3] = wd[31:24];
    end
  endtask

  function automatic logic [3:0] exp_be(int a, int sz);
    if (sz == 0) return 4'b0001 << (a % 4);
    if (sz == 1) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_din(int sz, logic [31:0] wd);
    if (sz == 0) return {24'd0, wd[7:0]} * 32'h01010101;
    if (sz == 1) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  always @(negedge clk) begin : mon
    logic [1:0] ev, gm;
    int g, a, sz, we;
    bit mis;
    if (rst) begin
      pend[0] = 0; pend[1] = 0; mptr = 0;
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    end else begin
      for (int c = 0; c < 2; c++) begin
        ev[c] = pend[c] && age[c] >= 2;
        chk($sformatf("resp_valid%0d", c), {31'd0, resp_valid[c]}, {31'd0, ev[c]});
        if (ev[c]) begin
          chk($sformatf("resp_rdata%0d", c), resp_rdata[c], exp_d[c]);
          chk($sformatf("resp_err%0d", c), {31'd0, resp_err[c]}, {31'd0, exp_e[c]});
        end
      end
      g = -1;
      if (req_valid[0] && !pend[0] && req_valid[1] && !pend[1]) g = mptr;
      else if (req_valid[0] && !pend[0]) g = 0;
      else if (req_valid[1] && !pend[1]) g = 1;
      gm = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      chk("req_ready", {30'd0, req_ready}, {30'd0, gm});
      if (g >= 0) begin
        a = int'(req_addr[g]); sz = int'(req_size[g]); we = int'(req_we[g]);
        mis = misal(a, sz);
        chk("sram_strobes", {30'd0, sram_wr_en, sram_rd_en},
            {30'd0, (we != 0) && !mis, (we == 0) && !mis});
        if (!mis) begin
          chk("sram_address", {22'd0, sram_address}, a / 4);
          chk("sram_byte_en", {28'd0, sram_byte_en}, {28'd0, exp_be(a, sz)});
          if (we != 0) chk("sram_data_in", sram_data_in, exp_din(sz, req_wdata[g]));
        end
      end else begin
        chk("sram_idle", {26'd0, sram_wr_en, sram_rd_en, sram_byte_en}, 32'd0);
      end
      for (int c = 0; c < 2; c++) begin
        if (ev[c] && resp_ready[c]) pend[c] = 0;
        else if (pend[c]) age[c]++;
      end
      if (g >= 0) begin
        mptr = (g == 0) ? 1 : 0;
        if (we != 0) begin
          if (!mis) ref_write(a, sz, req_wdata[g]);
        end else begin
          pend[g] = 1; age[g] = 1;
          exp_d[g] = mis ? 32'd0 : ref_read(a, sz);
          exp_e[g] = mis;
        end
      end
    end
  end

  task automatic issue(input int c, input int we, input int sz, input int a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output logic [3:0] be,
                       output logic rde, output int lat);
    bit acc = 0;
    @(posedge clk); #1;
    req_we[c] = we[0]; req_size[c] = sz[1:0]; req_addr[c] = a[AW-1:0]; req_wdata[c] = wd;
    req_valid[c] = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      if (req_ready[c]) begin acc = 1; be = sram_byte_en; rde = sram_rd_en; end
    end
    chk("accept_wait", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
    rd = 32'd0; er = 1'b0; lat = 0;
    if (we == 0 && acc) begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk); lat++;
        if (resp_valid[c]) begin got = 1; rd = resp_rdata[c]; er = resp_err[c]; end
      end
      chk("resp_wait", {31'd0, got}, 32'd1);
    end
  endtask

  typedef struct {
    int          c, we, sz, a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd;
    logic er, rde;
    logic [3:0] be;
    int lat, n0;
    int gq[$];

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) rmem[i] = 8'd0;
    pend[0] = 0; pend[1] = 0; mptr = 0;

    tbl[0]  = '{0, 1, 2, 'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[1]  = '{0, 0, 0, 'h10, 32'h0, 4'b0001, 32'h000000EF};
    tbl[2]  = '{0, 0, 0, 'h11, 32'h0, 4'b0010, 32'h000000BE};
    tbl[3]  = '{0, 0, 0, 'h12, 32'h0, 4'b0100, 32'h000000AD};
    tbl[4]  = '{0, 0, 0, 'h13, 32'h0, 4'b1000, 32'h000000DE};
    tbl[5]  = '{1, 0, 1, 'h12, 32'h0, 4'b1100, 32'h0000DEAD};
    tbl[6]  = '{0, 1, 2, 'h20, 32'hAAAAAAAA, 4'b1111, 32'h0};
    tbl[7]  = '{0, 1, 1, 'h22, 32'h00001234, 4'b1100, 32'h0};
    tbl[8]  = '{1, 0, 2, 'h20, 32'h0, 4'b1111, 32'h1234AAAA};
    tbl[9]  = '{1, 1, 0, 'h21, 32'h00000077, 4'b0010, 32'h0};
    tbl[10] = '{0, 0, 2, 'h20, 32'h0, 4'b1111, 32'h123477AA};
    tbl[11] = '{0, 0, 1, 'h20, 32'h0, 4'b0011, 32'h000077AA};

    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_size = '0; req_addr = '0;
    req_wdata = '0; resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_strobes", {30'd0, sram_wr_en, sram_rd_en}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
    chk("rst_rdata0", resp_rdata[0], 32'd0);
    chk("rst_rdata1", resp_rdata[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].c, tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, rd, er, be, rde, lat);
      chk($sformatf("tbl%0d_be", i), {28'd0, be}, {28'd0, tbl[i].be});
      if (tbl[i].we == 0) begin
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
        chk($sformatf("tbl%0d_latency", i), lat, 2);
      end
    end

    // Client 1 holds its response; client 0 must keep being served.
    @(posedge clk); #1;
    resp_ready = 2'b01;
    req_we[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 'h20; req_valid[1] = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (resp_valid[1]) got = 1;
      end
      chk("stall_resp_wait", {31'd0, got}, 32'd1);
    end
    @(posedge clk); #1;
    req_we[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 'h10; req_valid[0] = 1'b1;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid1", {31'd0, resp_valid[1]}, 32'd1);
      chk("stall_rdata1", resp_rdata[1], 32'h123477AA);
      chk("stall_ready1", {31'd0, req_ready[1]}, 32'd0);
      if (req_ready[0]) n0++;
    end
    chk("stall_c0_grants", n0, 2);
    @(posedge clk); #1;
    resp_ready = 2'b11; req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Misaligned word read at 0x03.
    issue(0, 1, 2, 'h00, 32'h0BADF00D, rd, er, be, rde, lat);
    issue(0, 0, 2, 'h03, 32'h0, rd, er, be, rde, lat);
    chk("mis_latency", lat, 2);
`ifdef SRAM_ARB_MISALIGN_ERR_EN
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_rd_en", {31'd0, rde}, 32'd0);
`else
    chk("mis_err", {31'd0, er}, 32'd0);
    chk("mis_rdata", rd, 32'h0BADF00D);
    chk("mis_rd_en", {31'd0, rde}, 32'd1);
`endif

    // Reset the cycle after a client 0 read accept: no response, pointer back to 0.
    @(posedge clk); #1;
    req_we[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 'h10; req_valid[0] = 1'b1;
    begin
      bit acc = 0;
      for (int i = 0; i < 10 && !acc; i++) begin
        @(negedge clk);
        if (req_ready[0]) acc = 1;
      end
      chk("rstrd_accept", {31'd0, acc}, 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstrd_no_resp", {30'd0, resp_valid}, 32'd0);
    end

    // Both clients reading every cycle: grants must alternate starting from client 0.
    @(posedge clk); #1;
    req_we = 2'b00; req_size[0] = 2'd2; req_size[1] = 2'd2;
    req_addr[0] = 'h10; req_addr[1] = 'h20; req_valid = 2'b11;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (req_ready[0]) gq.push_back(0);
      if (req_ready[1]) gq.push_back(1);
    end
    chk("arb_grant_count", gq.size() >= 4, 32'd1);
    if (gq.size() >= 4) begin
      chk("arb_g0", gq[0], 0);
      chk("arb_g1", gq[1], 1);
      chk("arb_g2", gq[2], 0);
      chk("arb_g3", gq[3], 1);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
        req_valid[c]  = ($urandom % 4) != 0;
        req_we[c]     = 1'($urandom % 2);
        req_size[c]   = 2'($urandom % 4);
        req_addr[c]   = AW'($urandom % 64);
        req_wdata[c]  = $urandom;
        resp_ready[c] = ($urandom % 4) != 0;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00; resp_ready = 2'b11;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mem_arbiter.md
# sram_mem_arbiter

Two-client request arbiter and lane-alignment front end sitting directly upstream of the byte-enabled single-port SRAM in the tracer memory subsystem. It accepts byte/half/word read and write requests from two clients over valid/ready handshakes and arbitrates round-robin. It translates byte addresses and access sizes into SRAM word address, byte enables and lane-shifted write data. It returns right-aligned, zero-extended read data per client through a one-entry response register.

## Interface
- DEPTH, 1024: SRAM depth in 32-bit words; power of two.
- AW, $clog2(DEPTH)+2: client byte-address width (derived).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  [1:0]  per-client request valid.
- req_ready  out  [1:0]  per-client request accepted this cycle when valid&ready.
- req_we  in  [1:0]  1 = write, 0 = read.
- req_size  in  [1:0][1:0]  0 byte, 1 half, 2 word, 3 reserved.
- req_addr  in  [1:0][AW-1:0]  byte address.
- req_wdata  in  [1:0][31:0]  right-aligned write data.
- resp_valid  out  [1:0]  read response valid.
- resp_ready  in  [1:0]  client consumes response.
- resp_rdata  out  [1:0][31:0]  right-aligned, zero-extended read data.
- resp_err  out  [1:0]  misaligned/reserved-size flag (0 unless macro enabled).
- sram_wr_en, sram_rd_en  out  1  SRAM strobes.
- sram_address  out  $clog2(DEPTH)  word address = req_addr[AW-1:2].
- sram_data_in  out  32  lane-shifted write data.
- sram_byte_en  out  4  lane enables.
- sram_data_out  in  32  SRAM read data, valid one cycle after sram_rd_en.

## Operation
- Client c eligible when req_valid[c], not in reset, no read in flight for c, and resp_valid[c]=0.
- Round-robin: pointer ptr (reset 0). Both eligible: grant ptr. One eligible: grant it. After any grant, ptr <= ~granted client.
- req_ready[c] = grant[c], combinational; at most one bit set.
- SRAM outputs combinational from granted request; all-zero when no grant.
- Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111. sram_data_in = wdata replicated to all lanes (byte x4, half x2).
- Writes posted: no response.
- Read: inflight register records client; next cycle sram_data_out lane-extracted (shift right by 8*a[1:0] or 16*a[1], mask to size), loaded into resp_rdata[c], resp_valid[c] set.
- resp_valid[c] clears on resp_valid&resp_ready.
- Non-macro alignment: half ignores a[0], word ignores a[1:0]; size 3 treated as word.

## Timing
- Reset values: resp_valid 0, resp_rdata 0, resp_err 0, ptr 0, inflight 0; req_ready 0 and SRAM strobes 0 while rst high.
- Read latency: accept in cycle T, SRAM registers at edge ending T, resp_valid high in T+2.
- Per-client read throughput: one per 3 cycles minimum; writes one per cycle per granted client.
- Write in cycle T visible to a read accepted in T+1.
- Read and consume on same client: resp_ready in cycle k frees the slot; new grant earliest k+1.
- Reset during in-flight read: read discarded, no response after reset.
- resp_rdata held stable while resp_valid&~resp_ready.

## Configuration
- SRAM_ARB_MISALIGN_ERR_EN defined: half with a[0]=1, word with a[1:0]!=0, or size 3 is accepted but not issued to SRAM (strobes 0). Reads: resp_valid in T+2 with resp_err=1, resp_rdata=0. Writes: dropped silently.
- Undefined: resp_err tied 0; low address bits ignored as above.

## Structure
- Package sram_arb_pkg: access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), NUM_CLIENTS=2, byte-enable/lane-shift helper functions.
- Sub-module sram_lane_align: combinational read extraction (word, offset, size -> right-aligned data).

## Test plan
- Client 0 word write 0xDEADBEEF @0x10, then byte reads @0x10..0x13 -> 0xEF, 0xBE, 0xAD, 0xDE, each resp_valid 2 cycles after accept.
- Half write 0x1234 @0x22 over word 0xAAAAAAAA @0x20 -> sram_byte_en 4'b1100; word read @0x20 -> 0x1234AAAA.
- Both clients valid every cycle, reads -> grants alternate 0,1,0,1 from reset; no client starved.
- resp_ready[1] held low 5 cycles -> resp_rdata stable, req_ready[1]=0 throughout, client 0 keeps being granted.
- rst asserted cycle after read accept -> no resp_valid after reset, ptr=0.
- Macro on: word read @0x03 -> resp_err=1, resp_rdata=0, sram_rd_en never high; macro off: same read returns word @0x00.
